pipe_control: RTL and testbench

- Pipelined successor to the single-cycle RV32I control decoder.
- Decodes the ID-stage instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Adds a load-use interlock, a branch/jump redirect flush, and an optional multi-cycle MUL/DIV hold counter.
- Sits between the fetch unit, the datapath stage registers and the register-file write port.

---
 rtl/pipe_control.sv | 168 ++++++++++++++++
 tb/tb_pipe_control.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - RV32I pipelined control: decode, ID/EX/MEM/WB control registers,
// load-use interlock, redirect flush and multi-cycle MUL/DIV hold.
module pipe_control #(
  parameter int MULDIV_CYCLES = 4,
  parameter bit EN_MULDIV     = 1'b1,
  parameter int RA_W          = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     id_instr,
  input  logic            id_valid,
  input  logic            ex_redirect,
  output logic            stall_if,
  output logic            flush_id,
  output logic            muldiv_busy,
  output logic            ex_valid,
  output logic            ex_immreg,
  output logic            ex_brinst,
  output logic            ex_jaljalr,
  output logic            ex_muldiv,
  output logic            mem_valid,
  output logic            mem_dmwenable,
  output logic            mem_useDM,
  output logic            wb_rfwenable,
  output logic [1:0]      wb_sel,
  output logic [RA_W-1:0] wb_rd
);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_DM  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_MD  = 2'b11;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  typedef struct packed {
    logic            valid;
    logic            immreg;
    logic            brinst;
    logic            jaljalr;
    logic            muldiv;
    logic            dmwenable;
    logic            usedm;
    logic            rfwenable;
    logic [1:0]      wbsel;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
  } stage_t;

  stage_t     id_dec;
  stage_t     ex_q, ex_d;
  stage_t     mem_q, mem_d;
  stage_t     wb_q, wb_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] op;
  logic [6:0] funct7;
  logic       is_rtype, is_load, is_store, is_branch, is_jump;
  logic       uses_rs2;
  logic       busy;
  logic       redirect;
  logic       load_use;

  assign op        = id_instr[6:0];
  assign funct7    = id_instr[31:25];
  assign is_rtype  = (op == OP_RTYPE);
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jump   = (op == OP_JAL) || (op == OP_JALR);
  assign uses_rs2  = is_rtype || is_store || is_branch;

  always_comb begin
    id_dec           = '0;
    id_dec.valid     = id_valid;
    id_dec.immreg    = !is_rtype;
    id_dec.brinst    = is_branch;
    id_dec.jaljalr   = is_jump;
    id_dec.muldiv    = EN_MULDIV && is_rtype && (funct7 == F7_MULDIV);
    id_dec.dmwenable = is_store;
    id_dec.usedm     = is_load;
    id_dec.rd        = RA_W'(id_instr[11:7]);
    id_dec.rs1       = RA_W'(id_instr[19:15]);
    id_dec.rs2       = RA_W'(id_instr[24:20]);
    id_dec.rfwenable = !(is_store || is_branch) && (id_instr[11:7] != 5'd0);
    if (is_jump)
      id_dec.wbsel = WB_PC4;
    else if (is_load)
      id_dec.wbsel = WB_DM;
    else if (id_dec.muldiv)
      id_dec.wbsel = WB_MD;
    else
      id_dec.wbsel = WB_ALU;
  end

  // A held MUL/DIV cannot be a branch, so any redirect seen during the hold is spurious.
  assign busy     = (cnt_q != 4'd0);
  assign redirect = ex_redirect && !busy;

  assign load_use = ex_q.valid && ex_q.usedm && (ex_q.rd != '0) && id_valid &&
                    ((id_dec.rs1 == ex_q.rd) || (uses_rs2 && (id_dec.rs2 == ex_q.rd)));

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = mem_q;
    cnt_d = cnt_q;
    if (busy) begin
      mem_d = '0;
      cnt_d = cnt_q - 4'd1;
    end else begin
      mem_d = ex_q;
      if (redirect || load_use || !id_valid)
        ex_d = '0;
      else
        ex_d = id_dec;
      cnt_d = (ex_d.valid && ex_d.muldiv) ? MD_LOAD : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= 4'd0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  // A MUL/DIV hold already freezes ID, so a coincident load-use adds no extra stall.
  assign stall_if    = busy || (load_use && !redirect);
  assign flush_id    = redirect;
  assign muldiv_busy = busy;

  assign ex_valid   = ex_q.valid;
  assign ex_immreg  = ex_q.valid && ex_q.immreg;
  assign ex_brinst  = ex_q.valid && ex_q.brinst;
  assign ex_jaljalr = ex_q.valid && ex_q.jaljalr;
  assign ex_muldiv  = ex_q.valid && ex_q.muldiv;

  assign mem_valid     = mem_q.valid;
  assign mem_dmwenable = mem_q.valid && mem_q.dmwenable;
  assign mem_useDM     = mem_q.valid && mem_q.usedm;

  assign wb_rfwenable = wb_q.valid && wb_q.rfwenable;
  assign wb_sel       = wb_q.valid ? wb_q.wbsel : WB_ALU;
  assign wb_rd        = wb_q.valid ? wb_q.rd : '0;

  // Source registers and late-stage control travel with the instruction for the datapath.
  logic unused_ok;
  assign unused_ok = ^{id_instr[14:12], wb_q.immreg, wb_q.brinst, wb_q.jaljalr,
                       wb_q.muldiv, wb_q.dmwenable, wb_q.usedm, wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - directed and randomized check of pipe_control against a reference model.
module tb_pipe_control;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instr = 32'h0;
  logic        id_valid = 1'b0;
  logic        ex_redirect = 1'b0;
  logic        stall_if, flush_id, muldiv_busy;
  logic        ex_valid, ex_immreg, ex_brinst, ex_jaljalr, ex_muldiv;
  logic        mem_valid, mem_dmwenable, mem_useDM;
  logic        wb_rfwenable;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  pipe_control #(.MULDIV_CYCLES(MC), .EN_MULDIV(1'b1), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .stall_if(stall_if), .flush_id(flush_id), .muldiv_busy(muldiv_busy),
    .ex_valid(ex_valid), .ex_immreg(ex_immreg), .ex_brinst(ex_brinst),
    .ex_jaljalr(ex_jaljalr), .ex_muldiv(ex_muldiv),
    .mem_valid(mem_valid), .mem_dmwenable(mem_dmwenable), .mem_useDM(mem_useDM),
    .wb_rfwenable(wb_rfwenable), .wb_sel(wb_sel), .wb_rd(wb_rd)
  );

  // Reference: what each instruction means, and where it sits in a 3-slot pipe.
  typedef struct {
    bit       valid;
    bit       reg_op, branch, jump, md, store, load, writes;
    bit [1:0] sel;
    bit [4:0] rd, rs1, rs2;
  } insn_t;

  insn_t pl[3];          // 0 = EX, 1 = MEM, 2 = WB
  int    hold_left;
  bit    m_stall, m_flush;
  int    checks = 0;
  int    errors = 0;
  int    n_stall, n_busy, n_rfw, n_dmw;
  int    md_sel;

  function automatic insn_t meaning(input bit [31:0] w, input bit v);
    insn_t r;
    int    opc;
    opc      = int'(w[6:0]);
    r.valid  = v;
    r.reg_op = (opc == 'h33);
    r.load   = (opc == 'h03);
    r.store  = (opc == 'h23);
    r.branch = (opc == 'h63);
    r.jump   = (opc == 'h6F) || (opc == 'h67);
    r.md     = r.reg_op && (w[31:25] == 7'd1);
    r.rd     = w[11:7];
    r.rs1    = w[19:15];
    r.rs2    = w[24:20];
    r.writes = !r.store && !r.branch && (r.rd != 0);
    r.sel    = r.jump ? 2'd2 : r.load ? 2'd1 : r.md ? 2'd3 : 2'd0;
    return r;
  endfunction

  function automatic insn_t nothing();
    return meaning(32'h0, 1'b0);
  endfunction

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit [31:0] w, input bit redir);
    insn_t id;
    insn_t ex;
    bit    hazard, busy;
    @(negedge clk);
    rst = r; id_valid = v; id_instr = w; ex_redirect = redir;
    #1;
    id     = meaning(w, v);
    ex     = pl[0];
    busy   = hold_left > 0;
    hazard = ex.valid && ex.load && ex.rd != 0 && v &&
             (id.rs1 == ex.rd || ((id.reg_op || id.store || id.branch) && id.rs2 == ex.rd));
    m_flush = redir && !busy;
    m_stall = busy || (hazard && !m_flush);
    ck("stall_if", stall_if, m_stall);
    ck("flush_id", flush_id, m_flush);
    ck("muldiv_busy", muldiv_busy, busy);
    ck("ex_valid", ex_valid, ex.valid);
    ck("ex_immreg", ex_immreg, ex.valid && !ex.reg_op);
    ck("ex_brinst", ex_brinst, ex.valid && ex.branch);
    ck("ex_jaljalr", ex_jaljalr, ex.valid && ex.jump);
    ck("ex_muldiv", ex_muldiv, ex.valid && ex.md);
    ck("mem_valid", mem_valid, pl[1].valid);
    ck("mem_dmwenable", mem_dmwenable, pl[1].valid && pl[1].store);
    ck("mem_useDM", mem_useDM, pl[1].valid && pl[1].load);
    ck("wb_rfwenable", wb_rfwenable, pl[2].valid && pl[2].writes);
    ck("wb_sel", wb_sel, pl[2].valid ? pl[2].sel : 2'd0);
    ck("wb_rd", wb_rd, pl[2].valid ? pl[2].rd : 5'd0);
    n_stall += int'(stall_if);
    n_busy  += int'(muldiv_busy);
    n_rfw   += int'(wb_rfwenable);
    n_dmw   += int'(mem_dmwenable);
    if (wb_rfwenable && wb_rd == 5'd7) md_sel = int'(wb_sel);
    @(posedge clk);
    if (r) begin
      pl[0] = nothing(); pl[1] = nothing(); pl[2] = nothing();
      hold_left = 0;
    end else if (busy) begin
      pl[2] = pl[1];
      pl[1] = nothing();
      hold_left--;
    end else begin
      pl[2] = pl[1];
      pl[1] = pl[0];
      pl[0] = (v && !m_flush && !hazard) ? id : nothing();
      hold_left = (pl[0].valid && pl[0].md) ? MC - 1 : 0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic bit [31:0] rand_instr();
    bit [6:0] ops[8];
    bit [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    w = {6'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
         3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 7)]};
    return w;
  endfunction

  localparam bit [31:0] ADD_3_1_2  = 32'h002081B3;
  localparam bit [31:0] LW_5_0_1   = 32'h0000A283;
  localparam bit [31:0] ADD_6_5_2  = 32'h00228333;
  localparam bit [31:0] MUL_7_1_2  = 32'h022083B3;
  localparam bit [31:0] ADDI_0_0_1 = 32'h00100013;
  localparam bit [31:0] SW_2_0_1   = 32'h0020A023;

  initial begin
    bit [31:0] ins;
    bit        v, held;
    pl[0] = nothing(); pl[1] = nothing(); pl[2] = nothing();
    hold_left = 0;
    n_stall = 0; n_busy = 0; n_rfw = 0; n_dmw = 0; md_sel = -1;

    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    ck("reset_ex_valid", ex_valid, 1'b0);
    ck("reset_wb_rd", wb_rd, 5'd0);

    cyc(1'b0, 1'b1, ADD_3_1_2, 1'b0);
    #1 ck("add_ex_valid_1edge", ex_valid, 1'b1);
    idle(2);
    #1;
    ck("add_wb_rfw", wb_rfwenable, 1'b1);
    ck("add_wb_sel", wb_sel, 2'd0);
    ck("add_wb_rd", wb_rd, 5'd3);

    idle(3);
    n_stall = 0;
    cyc(1'b0, 1'b1, LW_5_0_1, 1'b0);
    cyc(1'b0, 1'b1, ADD_6_5_2, 1'b0);
    cyc(1'b0, 1'b1, ADD_6_5_2, 1'b0);
    idle(2);
    #1;
    ck("loaduse_stall_count", n_stall, 1);
    ck("loaduse_add_wb_rd", wb_rd, 5'd6);

    idle(3);
    cyc(1'b0, 1'b1, LW_5_0_1, 1'b0);
    cyc(1'b0, 1'b1, ADD_6_5_2, 1'b1);
    #1 ck("redirect_bubble", ex_valid, 1'b0);

    idle(3);
    n_busy = 0; md_sel = -1;
    cyc(1'b0, 1'b1, MUL_7_1_2, 1'b0);
    idle(8);
    ck("mul_busy_cycles", n_busy, MC - 1);
    ck("mul_wb_sel", md_sel, 3);

    n_rfw = 0; n_dmw = 0;
    cyc(1'b0, 1'b1, ADDI_0_0_1, 1'b0);
    cyc(1'b0, 1'b1, SW_2_0_1, 1'b0);
    idle(4);
    ck("x0_sw_no_rfw", n_rfw, 0);
    ck("sw_dmw_seen", n_dmw, 1);

    cyc(1'b0, 1'b1, MUL_7_1_2, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    ck("rst_mid_md_busy", muldiv_busy, 1'b0);
    ck("rst_mid_md_ex_valid", ex_valid, 1'b0);
    ck("rst_mid_md_stall", stall_if, 1'b0);

    held = 1'b0; v = 1'b1; ins = rand_instr();
    for (int i = 0; i < 4000; i++) begin
      if (!held) begin
        v   = ($urandom_range(0, 99) < 85);
        ins = rand_instr();
      end
      cyc(($urandom_range(0, 299) == 0), v, ins, ($urandom_range(0, 9) == 0));
      held = m_stall && !m_flush;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
